vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 103 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator: pixel/line counters, registered syncs, visible-area flag and strobes.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN; otherwise frame_cnt is tied to zero.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 10,
    parameter int FW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_cnt
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_DISPLAY + V_BOTTOM);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic [CW-1:0] hpos_q, hpos_d;
    logic [CW-1:0] vpos_q, vpos_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          h_wrap;
    logic          v_wrap;

    always_comb begin
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        h_wrap = (hpos_q == H_LAST);
        v_wrap = h_wrap && (vpos_q == V_LAST);
        if (ce) begin
            hpos_d = h_wrap ? '0 : hpos_q + 1'b1;
            if (h_wrap) begin
                vpos_d = v_wrap ? '0 : vpos_q + 1'b1;
            end
        end
        // Syncs decode the next position so they register alongside it with no lag.
        hsync_d = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FW-1:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (ce && v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = (hpos_q < H_VIS) && (vpos_q < V_VIS);
    assign line_start  = rst_n && ce && (hpos_q == '0);
    assign frame_start = line_start && (vpos_q == '0);

endmodule
